// File: rtl/gate_ctrl_pkg.sv
// gate_ctrl_pkg: opcode encodings and controller states for the bit-serial gate sequencer
package gate_ctrl_pkg;
    localparam logic [2:0] OP_AND     = 3'd0;
    localparam logic [2:0] OP_OR      = 3'd1;
    localparam logic [2:0] OP_NOT     = 3'd2;
    localparam logic [2:0] OP_NAND    = 3'd3;
    localparam logic [2:0] OP_NOR     = 3'd4;
    localparam logic [2:0] OP_XOR     = 3'd5;
    localparam logic [2:0] OP_XNOR    = 3'd6;
    localparam logic [2:0] OP_ILLEGAL = 3'd7;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/mux_gate_bit.sv
// mux_gate_bit: 1-bit gate built from a 2:1 mux selected by a, data chosen per opcode
module mux_gate_bit
    import gate_ctrl_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic [2:0] op,
    output logic       y
);
    logic d1, d0;
    assign d1 = (op == OP_AND || op == OP_XNOR) ? b :
                (op == OP_OR) ? 1'b1 :
                (op == OP_NAND || op == OP_XOR) ? ~b : 1'b0;
    assign d0 = (op == OP_OR || op == OP_XOR) ? b :
                (op == OP_NOT || op == OP_NAND) ? 1'b1 :
                (op == OP_NOR || op == OP_XNOR) ? ~b : 1'b0;
    assign y = a ? d1 : d0;
endmodule

// File: rtl/bitserial_gate_ctrl.sv
// bitserial_gate_ctrl: applies one gate op LSB-first through a single shared 1-bit mux gate
module bitserial_gate_ctrl
    import gate_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             err,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    state_t           state;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [2:0]       op_r;
    logic [CW-1:0]    cnt;
    logic             y;
    logic             last;
    mux_gate_bit u_gate (.a(a_sh[0]), .b(b_sh[0]), .op(op_r), .y(y));
    assign last = (cnt == CW'(WIDTH - 1));
    // DONE spends its first cycle raising out_valid/err, so the result appears WIDTH+1 edges after accept
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            result    <= '0;
            err       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            op_r      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sh     <= a;
                        b_sh     <= b;
                        op_r     <= op;
                        result   <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                RUN: begin
                    result <= {y, result[WIDTH-1:1]};
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    cnt    <= last ? cnt : cnt + 1'b1;
                    state  <= last ? DONE : RUN;
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        err       <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        out_valid <= 1'b1;
                        err       <= (op_r == OP_ILLEGAL);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bitserial_gate_ctrl.sv
// tb_bitserial_gate_ctrl: vector table, corner sequences and random ops against a word-level model
module tb_bitserial_gate_ctrl;
    logic       clk = 1'b0;
    logic       rst, in_valid, in_ready, out_valid, out_ready, err, busy;
    logic [2:0] op;
    logic [7:0] a, b, result;
    int         n_pass = 0, n_total = 0;
    bitserial_gate_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .err(err), .busy(busy)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [2:0] op;
        logic [7:0] a, b, exp_r;
        logic       exp_e;
    } vec_t;
    vec_t vecs[8];
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask
    function automatic logic [7:0] model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
        case (o)
            3'd0: return x & z;
            3'd1: return x | z;
            3'd2: return ~x;
            3'd3: return ~(x & z);
            3'd4: return ~(x | z);
            3'd5: return x ^ z;
            3'd6: return ~(x ^ z);
            default: return 8'h00;
        endcase
    endfunction
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask
    task automatic accept(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
        int w = 0;
        while (!in_ready && w < 30) begin
            step();
            w++;
        end
        check("in_ready_wait", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        op = o;
        a = x;
        b = z;
        step();
        in_valid = 1'b0;
        op = 3'($urandom);
        a = 8'($urandom);
        b = 8'($urandom);
    endtask
    task automatic wait_done(input bit noisy);
        int lat = 0;
        while (!out_valid && lat < 40) begin
            if (noisy) begin
                in_valid = 1'($urandom_range(0, 1));
                a = 8'($urandom);
                b = 8'($urandom);
            end
            step();
            lat++;
        end
        in_valid = 1'b0;
        check("latency", lat, 9);
        check("busy_done", {31'd0, busy}, 32'd1);
        check("in_ready_done", {31'd0, in_ready}, 32'd0);
    endtask
    task automatic finish_op();
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("out_valid_clr", {31'd0, out_valid}, 32'd0);
        check("err_clr", {31'd0, err}, 32'd0);
        check("busy_clr", {31'd0, busy}, 32'd0);
        check("in_ready_lag", {31'd0, in_ready}, 32'd0);
        step();
        check("in_ready_back", {31'd0, in_ready}, 32'd1);
    endtask
    initial begin
        vecs[0] = '{3'd5, 8'hC5, 8'h3A, 8'hFF, 1'b0};
        vecs[1] = '{3'd0, 8'hC5, 8'h3A, 8'h00, 1'b0};
        vecs[2] = '{3'd3, 8'hF0, 8'hCC, 8'h3F, 1'b0};
        vecs[3] = '{3'd4, 8'hF0, 8'hCC, 8'h03, 1'b0};
        vecs[4] = '{3'd6, 8'hF0, 8'hCC, 8'hC3, 1'b0};
        vecs[5] = '{3'd2, 8'h5A, 8'hFF, 8'hA5, 1'b0};
        vecs[6] = '{3'd1, 8'h50, 8'h0A, 8'h5A, 1'b0};
        vecs[7] = '{3'd7, 8'hFF, 8'hFF, 8'h00, 1'b1};
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op = '0;
        a = '0;
        b = '0;
        repeat (3) step();
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_result", {24'd0, result}, 32'd0);
        rst = 1'b0;
        step();
        check("in_ready_after_rst", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            accept(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(1'b0);
            check($sformatf("vec%0d_result", i), {24'd0, result}, {24'd0, vecs[i].exp_r});
            check($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_e});
            finish_op();
        end
        // backpressure: result held, no second accept while DONE
        accept(3'd5, 8'hC5, 8'h3A);
        wait_done(1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            a = 8'($urandom);
            b = 8'($urandom);
            step();
            check("bp_result", {24'd0, result}, 32'hFF);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        finish_op();
        // reset during RUN at bit 4
        accept(3'd5, 8'hAA, 8'h0F);
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_result", {24'd0, result}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        check("mid_rst_in_ready_back", {31'd0, in_ready}, 32'd1);
        accept(3'd0, 8'hFF, 8'h0F);
        wait_done(1'b0);
        check("post_rst_and", {24'd0, result}, 32'h0F);
        finish_op();
        // random ops with in_valid noise while busy
        for (int i = 0; i < 25; i++) begin
            logic [2:0] o;
            logic [7:0] x, z;
            o = 3'($urandom);
            x = 8'($urandom);
            z = 8'($urandom);
            accept(o, x, z);
            wait_done(1'b1);
            check($sformatf("rand%0d_op%0d_result", i, o), {24'd0, result}, {24'd0, model(o, x, z)});
            check($sformatf("rand%0d_err", i), {31'd0, err}, {31'd0, o == 3'd7});
            repeat ($urandom_range(0, 2)) step();
            finish_op();
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
